serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 176 +++++++++++++++++
 tb/tb_serial_adder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial, LSB-first two's-complement adder. One full-adder cell and one
// carry flop process a single bit per clock, so an addition costs WIDTH
// RUN cycles plus one DONE cycle. Intended for slow control paths where
// area matters more than latency (e.g. address/offset accumulation).
//
// Handshake: a request is accepted on any rising edge where the FSM is IDLE
// and start=1; a/b/cin are captured on that same edge. busy is high from the
// accepting edge until the edge that leaves DONE. done is a one-cycle pulse
// during which sum/cout/ovf are valid. Results stay stable after done until
// the next completion or a reset. start while busy is dropped, not queued.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous, active-high reset (dominates everything)
//   start  in   1      request to begin an addition, sampled only in IDLE
//   a      in   WIDTH  operand A, captured on the accepting edge
//   b      in   WIDTH  operand B, captured on the accepting edge
//   cin    in   1      carry-in, captured on the accepting edge
//   busy   out  1      high while a request is in RUN or DONE
//   done   out  1      one-cycle pulse, sum/cout/ovf valid
//   sum    out  WIDTH  registered a+b+cin mod 2^WIDTH
//   cout   out  1      carry out of bit WIDTH-1
//   ovf    out  1      signed overflow (carry into MSB xor carry out of MSB)
//
// All outputs are driven from flops (busy/done decode the state register),
// so there is no combinational path from any input to any output.
// ----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Counter width: a 1-bit counter still works for WIDTH=1 (only value 0).
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // state is kept as a named signal so checkers can bind to it directly.
    state_t state;
    state_t state_next;

    // Datapath registers
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    bit_cnt;

    // Full-adder cell and derived signals
    logic             fa_s;
    logic             fa_c;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] s_msb;
    logic [WIDTH-1:0] sum_shifted;

    // ------------------------------------------------------------------------
    // Full-adder cell on the current LSBs and the carry flop.
    // ------------------------------------------------------------------------
    always_comb begin
        fa_s     = a_sh[0] ^ b_sh[0] ^ carry;
        fa_c     = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
        last_bit = (bit_cnt == LAST_BIT);
    end

    // ------------------------------------------------------------------------
    // Sum shift register input: the new bit enters at the MSB and everything
    // moves one place right. After WIDTH shifts bit i of the result has
    // landed in position i. Built with a mask rather than a concatenation so
    // the expression stays legal for WIDTH=1.
    // ------------------------------------------------------------------------
    always_comb begin
        s_msb            = '0;
        s_msb[WIDTH-1]   = fa_s;
        sum_shifted      = (sum_sh >> 1) | s_msb;
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: operand capture, bit-serial add, result load.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (accept) begin
                a_sh    <= a;
                b_sh    <= b;
                sum_sh  <= '0;
                carry   <= cin;
                bit_cnt <= '0;
            end else if (state == RUN) begin
                a_sh    <= a_sh >> 1;
                b_sh    <= b_sh >> 1;
                sum_sh  <= sum_shifted;
                carry   <= fa_c;
                bit_cnt <= bit_cnt + CW'(1);
                if (last_bit) begin
                    // carry still holds the carry into the MSB on this edge.
                    sum  <= sum_shifted;
                    cout <= fa_c;
                    ovf  <= carry ^ fa_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int tests = 0;
    int fails = 0;
    logic cmp_en = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Check helper
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: transaction-level. On acceptance the full result is
    // computed with plain arithmetic and queued; a countdown of the cycles
    // the request stays busy decides when done is due and results appear.
    // ------------------------------------------------------------------
    typedef logic [W+1:0] res_t;  // {ovf, cout, sum}
    res_t         exp_q[$];
    int           left   = 0;
    logic [W-1:0] m_sum  = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf  = 1'b0;
    logic [W:0]   m_full;
    logic         m_sovf;
    res_t         m_res;

    always @(posedge clk) begin
        if (rst) begin
            left = 0;
            exp_q.delete();
            m_sum  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (left == 0) begin
            if (start) begin
                m_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                // Signed overflow: operands share a sign and the result's sign differs.
                m_sovf = (a[W-1] == b[W-1]) && (m_full[W-1] != a[W-1]);
                exp_q.push_back({m_sovf, m_full});
                left = W + 1;
            end
        end else begin
            left--;
            if (left == 1) begin
                m_res = exp_q.pop_front();
                {m_ovf, m_cout, m_sum} = m_res;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard compare: every cycle, away from the active edge.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", {31'd0, busy}, {31'd0, (left > 0)});
            check("done", {31'd0, done}, {31'd0, (left == 1)});
            check("sum",  32'(sum),      32'(m_sum));
            check("cout", {31'd0, cout}, {31'd0, m_cout});
            check("ovf",  {31'd0, ovf},  {31'd0, m_ovf});
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    // Presents one start pulse; returns at the negedge after the accepting edge.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        @(negedge clk);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done; n counts negedges since the start pulse was driven.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (done !== 1'b1) begin
            if (n > 4 * W + 10) begin
                check("done_timeout", 32'd0, 32'd1);
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic directed(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic cv, input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        launch(av, bv, cv);
        wait_done(1, n);
        check({name, "_latency"}, 32'(n), 32'(W + 1));
        check({name, "_sum"},  32'(sum), 32'(es));
        check({name, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check({name, "_ovf"},  {31'd0, ovf},  {31'd0, eo});
        @(negedge clk);
        check({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int n;
        int ndone;
        int last_done;
        int cyc;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Reset then idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outputs", {busy, done, cout, ovf, sum}, 32'd0);
        end

        // Directed vectors with hand-computed results
        directed("wrap",     8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        directed("ovf_cin",  8'h3A, 8'h45, 1'b1, 8'h80, 1'b0, 1'b1);
        directed("neg_ovf",  8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        directed("no_carry", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

        // Start while busy: mid-RUN and during DONE, both ignored
        launch(8'h10, 8'h20, 1'b0);
        repeat (3) @(negedge clk);
        a     = 8'hFF;
        b     = 8'hFF;
        cin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, n);
        check("busy_start_latency", 32'(n), 32'(W + 1));
        check("busy_start_sum", 32'(sum), 32'h30);
        check("busy_start_cout", {31'd0, cout}, 32'd0);
        start = 1'b1;  // presented on the DONE edge
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("busy_start_no_second_done", 32'(ndone), 32'd0);
        check("busy_start_sum_held", 32'(sum), 32'h30);

        // Reset mid-operation
        launch(8'h55, 8'h55, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_outputs", {busy, done, cout, ovf, sum}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        directed("after_rst", 8'h55, 8'h55, 1'b0, 8'hAA, 1'b0, 1'b1);

        // Back-to-back with start held high and operands changing every cycle
        ndone     = 0;
        last_done = -1;
        cyc       = 0;
        @(negedge clk);
        start = 1'b1;
        while (ndone < 200 && cyc < 200 * (W + 2) + 50) begin
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                if (last_done >= 0) begin
                    check("b2b_spacing", 32'(cyc - last_done), 32'(W + 2));
                end
                last_done = cyc;
                ndone++;
            end
        end
        start = 1'b0;
        check("b2b_count", 32'(ndone), 32'd200);
        repeat (2 * W + 4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
